// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and data ports
// One transaction outstanding at a time; data wins unless a waiting fetch has been starved.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ifetch_req,
  input  logic [AW-1:0]   ifetch_addr,
  input  logic            ifetch_kill,
  output logic            ifetch_valid,
  output logic [DW-1:0]   ifetch_rdata,
  input  logic            dmem_req,
  input  logic            dmem_we,
  input  logic [DW/8-1:0] dmem_be,
  input  logic [AW-1:0]   dmem_addr,
  input  logic [DW-1:0]   dmem_wdata,
  output logic            dmem_done,
  output logic [DW-1:0]   dmem_rdata,
  output logic            stall_if,
  output logic            stall_mem,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, D_WAIT, I_WAIT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic            kill_q, kill_d;
  logic            ifetch_valid_q, ifetch_valid_d;
  logic            dmem_done_q, dmem_done_d;
  logic [DW-1:0]   ifetch_rdata_q, ifetch_rdata_d;
  logic [DW-1:0]   dmem_rdata_q, dmem_rdata_d;
  logic            sel_d, sel_i, starve_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      starve_q       <= '0;
      kill_q         <= 1'b0;
      ifetch_valid_q <= 1'b0;
      dmem_done_q    <= 1'b0;
      ifetch_rdata_q <= '0;
      dmem_rdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      starve_q       <= starve_d;
      kill_q         <= kill_d;
      ifetch_valid_q <= ifetch_valid_d;
      dmem_done_q    <= dmem_done_d;
      ifetch_rdata_q <= ifetch_rdata_d;
      dmem_rdata_q   <= dmem_rdata_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    kill_d         = kill_q;
    ifetch_valid_d = 1'b0;
    dmem_done_d    = 1'b0;
    ifetch_rdata_d = ifetch_rdata_q;
    dmem_rdata_d   = dmem_rdata_q;
    sel_d          = 1'b0;
    sel_i          = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_be         = '0;
    mem_addr       = '0;
    mem_wdata      = '0;
    starve_hit     = (starve_q == STARVE_LIM) && ifetch_req;

    case (state_q)
      IDLE: begin
        // The pipeline advances on the dmem_done edge, so issue nothing while it is high.
        if (!dmem_done_q) begin
          if (dmem_req && !starve_hit) begin
            sel_d = 1'b1;
          end else if (ifetch_req && !ifetch_valid_q && !ifetch_kill) begin
            sel_i = 1'b1;
          end
        end
        if (sel_d) begin
          mem_req   = 1'b1;
          mem_we    = dmem_we;
          mem_be    = dmem_be;
          mem_addr  = dmem_addr;
          mem_wdata = dmem_wdata;
          if (mem_gnt) state_d = D_WAIT;
        end else if (sel_i) begin
          mem_req  = 1'b1;
          mem_be   = '1;
          mem_addr = ifetch_addr;
          if (mem_gnt) begin
            state_d = I_WAIT;
            kill_d  = 1'b0;
          end
        end
      end
      D_WAIT: begin
        if (mem_rvalid) begin
          dmem_rdata_d = mem_rdata;
          dmem_done_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      I_WAIT: begin
        if (mem_rvalid) begin
          if (kill_q || ifetch_kill) begin
            kill_d = 1'b0;
          end else begin
            ifetch_rdata_d = mem_rdata;
            ifetch_valid_d = 1'b1;
          end
          state_d = IDLE;
        end else if (ifetch_kill) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    starve_d = starve_q;
    if (!ifetch_req || (sel_i && mem_gnt)) begin
      starve_d = '0;
    end else if (sel_d && mem_gnt && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + CW'(1);
    end
  end

  assign ifetch_valid = ifetch_valid_q;
  assign ifetch_rdata = ifetch_rdata_q;
  assign dmem_done    = dmem_done_q;
  assign dmem_rdata   = dmem_rdata_q;
  assign stall_if     = ifetch_req & ~ifetch_valid_q;
  assign stall_mem    = dmem_req & ~dmem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter
// Directed scenarios use literal expectations; the random phase uses a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk, reset;
  logic          ifetch_req, ifetch_kill, ifetch_valid;
  logic [AW-1:0] ifetch_addr;
  logic [DW-1:0] ifetch_rdata;
  logic          dmem_req, dmem_we, dmem_done;
  logic [3:0]    dmem_be;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata;
  logic          stall_if, stall_mem;
  logic          mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr), .ifetch_kill(ifetch_kill),
    .ifetch_valid(ifetch_valid), .ifetch_rdata(ifetch_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_done(dmem_done), .dmem_rdata(dmem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Transaction-level model state for the random phase
  int            m_out;     // 0 nothing outstanding, 1 data, 2 fetch
  bit            m_kill, m_done, m_ival, prev_done, prev_ival;
  int            m_starve, mem_wait;
  logic [DW-1:0] m_drd, m_ird;
  bit            iss_d, iss_i, forced;

  int            ng, done_cnt;
  logic [7:0]    gseq;
  bit            prev_gnt;

  initial begin
    reset = 1'b0;
    ifetch_req = 0; ifetch_addr = '0; ifetch_kill = 0;
    dmem_req = 0; dmem_we = 0; dmem_be = '0; dmem_addr = '0; dmem_wdata = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    sample();
    chk("rst_ifetch_valid", ifetch_valid, 0);
    chk("rst_dmem_done", dmem_done, 0);
    chk("rst_rdata", {ifetch_rdata, dmem_rdata}, 0);
    chk("rst_mem_req", mem_req, 0);

    // Fetch only, minimum latency
    step(); ifetch_req = 1; ifetch_addr = 32'h0; mem_gnt = 1; sample();
    chk("t1_mem_req", mem_req, 1);
    chk("t1_stall_if_c0", stall_if, 1);
    step(); mem_rvalid = 1; mem_rdata = 32'h00500093; sample();
    chk("t1_valid_c1", ifetch_valid, 0);
    step(); sample();
    chk("t1_valid_c2", ifetch_valid, 1);
    chk("t1_rdata", ifetch_rdata, 32'h00500093);
    chk("t1_stall_if_c2", stall_if, 0);
    step(); ifetch_req = 0; sample();
    chk("t1_pulse", ifetch_valid, 0);

    // Load and fetch together: data first
    step(); dmem_req = 1; dmem_we = 0; dmem_be = 4'hF; dmem_addr = 32'h100;
    ifetch_req = 1; ifetch_addr = 32'h4; mem_gnt = 1; sample();
    chk("t2_addr_data", mem_addr, 32'h100);
    chk("t2_stall_if", stall_if, 1);
    step(); mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; sample();
    step(); sample();
    chk("t2_done", dmem_done, 1);
    chk("t2_drdata", dmem_rdata, 32'hDEADBEEF);
    chk("t2_no_issue", mem_req, 0);
    step(); dmem_req = 0; mem_gnt = 1; sample();
    chk("t2_fetch_req", mem_req, 1);
    chk("t2_fetch_addr", mem_addr, 32'h4);
    step(); mem_rvalid = 1; mem_rdata = 32'h13; sample();
    step(); sample();
    chk("t2_fetch_valid", ifetch_valid, 1);
    step(); ifetch_req = 0; sample();

    // Store with delayed grant
    for (int k = 0; k < 3; k++) begin
      step();
      if (k == 0) begin
        dmem_req = 1; dmem_we = 1; dmem_be = 4'b0011; dmem_addr = 32'h200; dmem_wdata = 32'h1234ABCD;
      end
      sample();
      chk("t3_req_we_be", {mem_req, mem_we, mem_be}, {1'b1, 1'b1, 4'b0011});
      chk("t3_addr_wdata", {mem_addr, mem_wdata}, {32'h200, 32'h1234ABCD});
      chk("t3_stall_mem", stall_mem, 1);
    end
    step(); mem_gnt = 1; sample();
    chk("t3_req_at_gnt", mem_req, 1);
    step(); mem_rvalid = 1; mem_rdata = 32'hA5A5A5A5; sample();
    chk("t3_stall_wait", stall_mem, 1);
    chk("t3_no_done_yet", dmem_done, 0);
    step(); sample();
    chk("t3_done", dmem_done, 1);
    chk("t3_stall_clear", stall_mem, 0);
    chk("t3_store_ack_data", dmem_rdata, 32'hA5A5A5A5);
    step(); dmem_req = 0; dmem_we = 0; sample();

    // Fetch killed after grant
    step(); ifetch_req = 1; ifetch_addr = 32'h40; mem_gnt = 1; sample();
    step(); ifetch_kill = 1; ifetch_addr = 32'h80; sample();
    step(); ifetch_kill = 0; mem_rvalid = 1; mem_rdata = 32'hBAD; sample();
    chk("t4_no_valid_c2", ifetch_valid, 0);
    step(); mem_gnt = 1; sample();
    chk("t4_no_valid_c3", ifetch_valid, 0);
    chk("t4_refetch_req", mem_req, 1);
    chk("t4_refetch_addr", mem_addr, 32'h80);
    step(); mem_rvalid = 1; mem_rdata = 32'h11; sample();
    step(); sample();
    chk("t4_new_valid", ifetch_valid, 1);
    chk("t4_new_rdata", ifetch_rdata, 32'h11);
    step(); ifetch_req = 0; sample();

    // Starvation: six loads with a fetch waiting
    step();
    ifetch_req = 1; ifetch_addr = 32'h300;
    dmem_req = 1; dmem_we = 0; dmem_be = 4'hF; dmem_addr = 32'h1000;
    ng = 0; gseq = '0; prev_gnt = 0; done_cnt = 0;
    for (int c = 0; c < 80 && done_cnt < 6; c++) begin
      if (c != 0) step();
      mem_gnt = 1; mem_rvalid = prev_gnt; mem_rdata = 32'(c);
      sample();
      if (mem_req) begin
        if (ng < 8) gseq[ng] = (mem_addr < 32'h1000);
        ng++;
      end
      prev_gnt = mem_req;
      if (dmem_done) begin done_cnt++; dmem_addr = dmem_addr + 4; end
      if (ifetch_valid) ifetch_addr = ifetch_addr + 4;
    end
    chk("t5_loads_done", done_cnt, 6);
    chk("t5_grant_count", ng, 7);
    chk("t5_grant_order", gseq[6:0], 7'b0010000);
    step(); ifetch_req = 0; dmem_req = 0; sample();
    repeat (3) begin step(); sample(); end

    // Reset during D_WAIT, late rvalid ignored
    step(); dmem_req = 1; dmem_we = 0; dmem_be = 4'hF; dmem_addr = 32'h500; mem_gnt = 1; sample();
    step(); reset = 0; dmem_req = 0; #1;
    chk("t6_rst_drdata", dmem_rdata, 0);
    chk("t6_rst_irdata", ifetch_rdata, 0);
    chk("t6_rst_outs", {dmem_done, ifetch_valid, mem_req}, 0);
    step();
    step(); reset = 1; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D; sample();
    chk("t6_no_req", mem_req, 0);
    step(); sample();
    chk("t6_no_done", dmem_done, 0);
    chk("t6_drdata_zero", dmem_rdata, 0);
    mem_rvalid = 0; mem_gnt = 0;

    // Randomized phase
    m_out = 0; m_kill = 0; m_done = 0; m_ival = 0; m_starve = 0; mem_wait = 0;
    m_drd = '0; m_ird = '0; prev_done = 0; prev_ival = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (prev_done) begin
        dmem_req = ($urandom_range(0, 1) == 1);
        dmem_we = $urandom_range(0, 1); dmem_be = 4'($urandom);
        dmem_addr = $urandom & 32'hFFFC; dmem_wdata = $urandom;
      end else if (!dmem_req && $urandom_range(0, 2) == 0) begin
        dmem_req = 1; dmem_we = $urandom_range(0, 1); dmem_be = 4'($urandom);
        dmem_addr = $urandom & 32'hFFFC; dmem_wdata = $urandom;
      end
      if (prev_ival) begin
        ifetch_addr = ifetch_addr + 4;
        ifetch_req = ($urandom_range(0, 4) != 0);
      end else if (!ifetch_req && $urandom_range(0, 2) == 0) begin
        ifetch_req = 1;
      end
      ifetch_kill = ifetch_req && ($urandom_range(0, 9) == 0);
      if (ifetch_kill) ifetch_addr = $urandom & 32'hFFFC;

      forced = (m_starve == SM) && ifetch_req;
      iss_d = (m_out == 0) && !m_done && dmem_req && !forced;
      iss_i = (m_out == 0) && !m_done && !iss_d && ifetch_req && !m_ival && !ifetch_kill;

      mem_rvalid = 0;
      if (mem_wait > 0) begin
        mem_wait--;
        if (mem_wait == 0) begin mem_rvalid = 1; mem_rdata = $urandom; end
      end else if (m_out == 0 && $urandom_range(0, 19) == 0) begin
        mem_rvalid = 1; mem_rdata = $urandom;
      end
      mem_gnt = (iss_d || iss_i) && ($urandom_range(0, 2) != 0);
      #2;

      chk("r_mem_req", mem_req, iss_d || iss_i);
      if (iss_d) begin
        chk("r_d_fields", {mem_we, mem_be, mem_addr}, {dmem_we, dmem_be, dmem_addr});
        chk("r_d_wdata", mem_wdata, dmem_wdata);
      end
      if (iss_i) chk("r_i_fields", {mem_we, mem_addr, mem_wdata}, {1'b0, ifetch_addr, 32'h0});
      chk("r_done", dmem_done, m_done);
      chk("r_ival", ifetch_valid, m_ival);
      chk("r_rdata", {dmem_rdata, ifetch_rdata}, {m_drd, m_ird});
      chk("r_stalls", {stall_if, stall_mem}, {ifetch_req && !m_ival, dmem_req && !m_done});

      prev_done = m_done; prev_ival = m_ival;
      m_done = 0; m_ival = 0;
      if (m_out == 1 && mem_rvalid) begin
        m_done = 1; m_drd = mem_rdata; m_out = 0;
      end else if (m_out == 2) begin
        if (mem_rvalid) begin
          if (m_kill || ifetch_kill) m_kill = 0;
          else begin m_ival = 1; m_ird = mem_rdata; end
          m_out = 0;
        end else if (ifetch_kill) m_kill = 1;
      end else if (iss_d && mem_gnt) begin
        m_out = 1; mem_wait = $urandom_range(1, 3);
      end else if (iss_i && mem_gnt) begin
        m_out = 2; m_kill = 0; mem_wait = $urandom_range(1, 3);
      end
      if (!ifetch_req || (iss_i && mem_gnt)) m_starve = 0;
      else if (iss_d && mem_gnt && m_starve < SM) m_starve++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
